// File: rtl/vram_pkg.sv
// Shared types and default geometry for the VRAM line-fetch arbiter.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    YIELD = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 12;
  localparam int DEF_ADDR_W    = 15;
  localparam int DEF_LINE_LEN  = 160;
  localparam int DEF_NUM_LINES = 120;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_LB_AW     = $clog2(DEF_LINE_LEN);
  localparam int LINE_IDX_W    = 7;

endpackage

// File: rtl/vram_arbiter_if.sv
// Line-request, line-buffer, host-write and VRAM buses of the arbiter.
// VRAM_ARB_PERF_EN adds the performance counter outputs.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LB_AW  = DEF_LB_AW
);

  logic                  line_req;
  logic [LINE_IDX_W-1:0] line_idx;
  logic                  line_busy;
  logic                  line_done;

  logic                  lb_we;
  logic [LB_AW-1:0]      lb_addr;
  logic [DATA_W-1:0]     lb_wdata;

  logic                  wr_valid;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  logic                  err_clr;
  logic                  overrun;
  logic                  range_err;
`ifdef VRAM_ARB_PERF_EN
  logic [15:0]           host_stall_cnt;
  logic [7:0]            overrun_cnt;
`endif

  modport master (
    input  line_req, line_idx, wr_valid, wr_addr, wr_data, ram_rdata, err_clr,
    output line_busy, line_done, lb_we, lb_addr, lb_wdata, wr_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, overrun, range_err
`ifdef VRAM_ARB_PERF_EN
    , output host_stall_cnt, overrun_cnt
`endif
  );

  modport slave (
    output line_req, line_idx, wr_valid, wr_addr, wr_data, ram_rdata, err_clr,
    input  line_busy, line_done, lb_we, lb_addr, lb_wdata, wr_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, overrun, range_err
`ifdef VRAM_ARB_PERF_EN
    , input host_stall_cnt, overrun_cnt
`endif
  );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: line fetches into a line buffer, host writes in idle and at burst yield points.
// Define VRAM_ARB_PERF_EN to add saturating host-stall and overrun counters.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_LEN  = DEF_LINE_LEN,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  vram_arbiter_if.master bus
);

  localparam int LB_AW = $clog2(LINE_LEN);
  localparam int BC_W  = $clog2(BURST_LEN + 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [LB_AW-1:0]   r_off;
  logic [BC_W-1:0]    r_bcnt;
  logic               r_lb_we;
  logic [LB_AW-1:0]   r_lb_addr;
  logic               r_done;
  logic               r_overrun;
  logic               r_range_err;

  logic               w_busy;
  logic               w_idx_ok;
  logic               w_req_ok;
  logic               w_req_bad;
  logic               w_ovr_evt;
  logic               w_last;
  logic               w_burst_end;
  logic               w_wr_ready;
  logic               w_ram_en;
  logic               w_ram_we;
  logic [ADDR_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0]  w_ram_wdata;

  // Busy spans the trailing line-buffer write, so a request on the done cycle is an overrun.
  assign w_busy      = (r_state != IDLE) || r_done;
  assign w_idx_ok    = int'(bus.line_idx) < NUM_LINES;
  assign w_req_ok    = bus.line_req && !w_busy && w_idx_ok;
  assign w_req_bad   = bus.line_req && !w_busy && !w_idx_ok;
  assign w_ovr_evt   = bus.line_req && w_busy;
  assign w_last      = (r_off == LB_AW'(LINE_LEN - 1));
  assign w_burst_end = (r_bcnt == BC_W'(BURST_LEN - 1));

  always_comb begin
    w_wr_ready  = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (rst_n) begin
      case (r_state)
        IDLE:    w_wr_ready = !bus.line_req;
        FETCH: begin
          w_ram_en   = 1'b1;
          w_ram_addr = r_base + ADDR_W'(r_off);
        end
        YIELD:   w_wr_ready = 1'b1;
        default: w_wr_ready = 1'b0;
      endcase
      if (w_wr_ready && bus.wr_valid) begin
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_addr  = bus.wr_addr;
        w_ram_wdata = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_off     <= '0;
      r_bcnt    <= '0;
      r_lb_we   <= 1'b0;
      r_lb_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      // Read data lands one cycle after the command, so the buffer write trails the read.
      r_lb_we   <= (r_state == FETCH);
      r_lb_addr <= r_off;
      r_done    <= (r_state == FETCH) && w_last;
      case (r_state)
        IDLE: begin
          if (w_req_ok) begin
            r_state <= FETCH;
            r_base  <= ADDR_W'(32'(bus.line_idx) * 32'(LINE_LEN));
            r_off   <= '0;
            r_bcnt  <= '0;
          end
        end
        FETCH: begin
          if (w_last) begin
            r_state <= IDLE;
            r_off   <= '0;
            r_bcnt  <= '0;
          end else begin
            r_off <= r_off + LB_AW'(1);
            if (w_burst_end) begin
              r_bcnt <= '0;
              if (bus.wr_valid) r_state <= YIELD;
            end else begin
              r_bcnt <= r_bcnt + BC_W'(1);
            end
          end
        end
        YIELD:   r_state <= FETCH;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A fresh error event takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      if (w_ovr_evt)        r_overrun <= 1'b1;
      else if (bus.err_clr) r_overrun <= 1'b0;
      if (w_req_bad)        r_range_err <= 1'b1;
      else if (bus.err_clr) r_range_err <= 1'b0;
    end
  end

  assign bus.line_busy = w_busy;
  assign bus.line_done = r_done;
  assign bus.lb_we     = r_lb_we;
  assign bus.lb_addr   = r_lb_addr;
  assign bus.lb_wdata  = r_lb_we ? bus.ram_rdata : '0;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.ram_en    = w_ram_en;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;
  assign bus.overrun   = r_overrun;
  assign bus.range_err = r_range_err;

`ifdef VRAM_ARB_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_ovr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_ovr_cnt   <= '0;
    end else if (bus.err_clr) begin
      r_stall_cnt <= '0;
      r_ovr_cnt   <= '0;
    end else begin
      if (bus.wr_valid && !w_wr_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_ovr_evt && (r_ovr_cnt != '1))                     r_ovr_cnt   <= r_ovr_cnt + 8'd1;
    end
  end

  assign bus.host_stall_cnt = r_stall_cnt;
  assign bus.overrun_cnt    = r_ovr_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered single-port VRAM model.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if vif();

  vram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] mem [0:32767];

  function automatic int pat(input int a);
    return (a * 37 + 11) & 'hFFF;
  endfunction

  always @(posedge clk) begin
    if (vif.ram_en && vif.ram_we)  mem[vif.ram_addr] <= vif.ram_wdata;
    if (vif.ram_en && !vif.ram_we) vif.ram_rdata <= mem[vif.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected schedule: with a host write pending, every 17th cycle is a yield until 9 have occurred.
  task automatic run_fetch(input int idx, input bit hold_wr, input int req2_at);
    int base, done_cyc, prev_r, lb_cnt, r;
    int e_en, e_we, e_addr, e_wd, e_rdy;
    bit yld;
    base     = idx * 160;
    done_cyc = hold_wr ? 170 : 161;
    prev_r   = 0;
    lb_cnt   = 0;
    @(negedge clk);
    vif.line_req = 1'b1;
    vif.line_idx = 7'(idx);
    if (hold_wr) begin
      vif.wr_valid = 1'b1;
      vif.wr_addr  = 15'h100;
      vif.wr_data  = 12'hABC;
    end
    #1;
    chk("req_wr_ready", 32'(vif.wr_ready), 0);
    chk("req_ram_en", 32'(vif.ram_en), 0);
    for (int c = 1; c <= done_cyc + 2; c++) begin
      @(negedge clk);
      if (c == 1 || c == req2_at + 1) vif.line_req = 1'b0;
      r   = 0;
      yld = 1'b0;
      if (c < done_cyc) begin
        if (hold_wr) begin
          yld = ((c - 1) % 17 == 16);
          r   = yld ? 0 : ((c - 1) / 17) * 16 + (c - 1) % 17 + 1;
        end else begin
          r = c;
        end
      end
      e_en   = (r != 0 || yld) ? 1 : 0;
      e_we   = yld ? 1 : 0;
      e_addr = yld ? 'h100 : (r != 0 ? base + r - 1 : 0);
      e_wd   = yld ? 'hABC : 0;
      e_rdy  = (yld || c >= done_cyc) ? 1 : 0;
      chk($sformatf("ram_en@%0d", c), 32'(vif.ram_en), e_en);
      chk($sformatf("ram_we@%0d", c), 32'(vif.ram_we), e_we);
      chk($sformatf("ram_addr@%0d", c), 32'(vif.ram_addr), e_addr);
      chk($sformatf("ram_wdata@%0d", c), 32'(vif.ram_wdata), e_wd);
      chk($sformatf("wr_ready@%0d", c), 32'(vif.wr_ready), e_rdy);
      chk($sformatf("lb_we@%0d", c), 32'(vif.lb_we), (prev_r != 0) ? 1 : 0);
      if (prev_r != 0) begin
        chk($sformatf("lb_addr@%0d", c), 32'(vif.lb_addr), prev_r - 1);
        chk($sformatf("lb_wdata@%0d", c), 32'(vif.lb_wdata), pat(base + prev_r - 1));
      end
      if (vif.lb_we) lb_cnt++;
      chk($sformatf("line_done@%0d", c), 32'(vif.line_done), (c == done_cyc) ? 1 : 0);
      chk($sformatf("line_busy@%0d", c), 32'(vif.line_busy), (c <= done_cyc) ? 1 : 0);
      prev_r = r;
      if (c == req2_at) begin
        vif.line_req = 1'b1;
        vif.line_idx = 7'd3;
      end
      if (c == done_cyc - 1) vif.wr_valid = 1'b0;
    end
    chk("lb_count", lb_cnt, 160);
  endtask

  initial begin
    int seen_done, seen_lb, seen_busy, seen_en;
    vif.line_req  = 1'b0;
    vif.line_idx  = '0;
    vif.wr_valid  = 1'b0;
    vif.wr_addr   = '0;
    vif.wr_data   = '0;
    vif.err_clr   = 1'b0;
    vif.ram_rdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 12'(pat(i));

    // Outputs held low in reset even with requests pending.
    vif.wr_valid = 1'b1;
    vif.line_req = 1'b1;
    vif.line_idx = 7'd2;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_ready", 32'(vif.wr_ready), 0);
    chk("rst_ram_en", 32'(vif.ram_en), 0);
    chk("rst_line_busy", 32'(vif.line_busy), 0);
    chk("rst_lb_we", 32'(vif.lb_we), 0);
    chk("rst_overrun", 32'(vif.overrun), 0);
    vif.wr_valid = 1'b0;
    vif.line_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Idle host write passes straight through.
    @(negedge clk);
    vif.wr_valid = 1'b1;
    vif.wr_addr  = 15'h7FF0;
    vif.wr_data  = 12'h123;
    #1;
    chk("idle_wr_ready", 32'(vif.wr_ready), 1);
    chk("idle_ram_we", 32'(vif.ram_we), 1);
    chk("idle_ram_addr", 32'(vif.ram_addr), 'h7FF0);
    chk("idle_ram_wdata", 32'(vif.ram_wdata), 'h123);
    @(negedge clk);
    vif.wr_valid = 1'b0;
    chk("idle_mem", 32'(mem[15'h7FF0]), 'h123);

    run_fetch(2, 1'b0, 0);
    run_fetch(5, 1'b1, 0);
    chk("mem_0x100", 32'(mem[15'h100]), 'hABC);
    chk("no_overrun", 32'(vif.overrun), 0);
    run_fetch(3, 1'b0, 50);
    chk("overrun_set", 32'(vif.overrun), 1);
    vif.err_clr = 1'b1;
    @(negedge clk);
    vif.err_clr = 1'b0;
    chk("overrun_clr", 32'(vif.overrun), 0);

    // Out-of-range line index.
    vif.line_req = 1'b1;
    vif.line_idx = 7'd120;
    @(negedge clk);
    vif.line_req = 1'b0;
    chk("range_err", 32'(vif.range_err), 1);
    chk("range_busy", 32'(vif.line_busy), 0);
    chk("range_ram_en", 32'(vif.ram_en), 0);
    vif.err_clr  = 1'b1;
    vif.line_req = 1'b1;
    vif.line_idx = 7'd127;
    @(negedge clk);
    vif.line_req = 1'b0;
    chk("range_evt_wins", 32'(vif.range_err), 1);
    @(negedge clk);
    vif.err_clr = 1'b0;
    chk("range_clr", 32'(vif.range_err), 0);

    // Reset in the middle of a fetch of the last line.
    vif.line_req = 1'b1;
    vif.line_idx = 7'd119;
    @(negedge clk);
    vif.line_req = 1'b0;
    chk("l119_first_addr", 32'(vif.ram_addr), 19040);
    repeat (80) @(negedge clk);
    chk("l119_off80_addr", 32'(vif.ram_addr), 19120);
    rst_n = 1'b0;
    vif.wr_valid = 1'b1;
    #1;
    chk("mid_rst_ram_en", 32'(vif.ram_en), 0);
    chk("mid_rst_ram_we", 32'(vif.ram_we), 0);
    chk("mid_rst_lb_we", 32'(vif.lb_we), 0);
    chk("mid_rst_busy", 32'(vif.line_busy), 0);
    chk("mid_rst_done", 32'(vif.line_done), 0);
    chk("mid_rst_wr_ready", 32'(vif.wr_ready), 0);
    @(negedge clk);
    vif.wr_valid = 1'b0;
    rst_n = 1'b1;
    seen_done = 0;
    seen_lb   = 0;
    seen_busy = 0;
    seen_en   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (vif.line_done) seen_done++;
      if (vif.lb_we)     seen_lb++;
      if (vif.line_busy) seen_busy++;
      if (vif.ram_en)    seen_en++;
    end
    chk("post_rst_done", seen_done, 0);
    chk("post_rst_lb_we", seen_lb, 0);
    chk("post_rst_busy", seen_busy, 0);
    chk("post_rst_ram_en", seen_en, 0);

`ifdef VRAM_ARB_PERF_EN
    chk("perf_stall_rst", 32'(vif.host_stall_cnt), 0);
    vif.wr_valid = 1'b1;
    vif.line_req = 1'b1;
    vif.line_idx = 7'd120;
    repeat (70000) @(negedge clk);
    vif.wr_valid = 1'b0;
    vif.line_req = 1'b0;
    chk("perf_stall_sat", 32'(vif.host_stall_cnt), 65535);
    vif.err_clr = 1'b1;
    @(negedge clk);
    vif.err_clr = 1'b0;
    chk("perf_stall_clr", 32'(vif.host_stall_cnt), 0);
    chk("perf_ovr_cnt", 32'(vif.overrun_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters: DATA_W, default 12, pixel word width; ADDR_W, default 15, VRAM word address width; LINE_LEN, default 160, words per line; NUM_LINES, default 120, lines per frame; BURST_LEN, default 16, reads between host yield points.
REQ-002 clk  in  1  single clock, all logic rising-edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 line_req  in  1  one-cycle request to fetch one line into the line buffer.
REQ-005 line_idx  in  7  line number, sampled with line_req.
REQ-006 line_busy  out  1  high while a line fetch is in progress.
REQ-007 line_done  out  1  one-cycle pulse with the last line-buffer write.
REQ-008 lb_we / lb_addr / lb_wdata  out  1 / clog2(LINE_LEN) / DATA_W  line-buffer write port.
REQ-009 wr_valid / wr_addr / wr_data  in  1 / ADDR_W / DATA_W  host write request.
REQ-010 wr_ready  out  1  host write accepted this cycle when wr_valid && wr_ready.
REQ-011 ram_en / ram_we / ram_addr / ram_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port VRAM command.
REQ-012 ram_rdata  in  DATA_W  VRAM read data, valid exactly 1 cycle after a read command.
REQ-013 err_clr  in  1  clears sticky error flags.
REQ-014 overrun / range_err  out  1 / 1  sticky error flags.

Function
REQ-015 FSM states IDLE, FETCH, YIELD; ram_* and wr_ready decoded combinationally from state, counters and inputs.
REQ-016 IDLE: line_req with line_idx < NUM_LINES -> FETCH next cycle, base = line_idx*LINE_LEN, truncated to ADDR_W; otherwise wr_ready = 1 and an accepted write drives ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data in the same cycle.
REQ-017 Simultaneous line_req and wr_valid in IDLE: line_req wins, wr_ready = 0.
REQ-018 line_req with line_idx >= NUM_LINES: ignored, range_err set, state stays IDLE.
REQ-019 FETCH: one read per cycle, ram_addr = base + offset, offset 0..LINE_LEN-1; wr_ready = 0.
REQ-020 Every read returns one cycle later as lb_we=1, lb_addr=offset, lb_wdata=ram_rdata; this write completes even when the state has already left FETCH.
REQ-021 After every BURST_LEN reads, except after the final read: if wr_valid, go to YIELD for exactly one cycle with wr_ready = 1 and the host write issued, then return to FETCH; else continue reading.
REQ-022 After read LINE_LEN-1: go to IDLE; line_done pulses with the final lb_we, one cycle after the final read.
REQ-023 Latency: line_req at edge T, first read in cycle T+1, line_done in cycle T+LINE_LEN+1+k, where k = number of yields.
REQ-024 line_req while line_busy: ignored, overrun set, the fetch in progress is unaffected.
REQ-025 line_busy = 1 from the FETCH entry cycle through the line_done cycle inclusive.
REQ-026 err_clr clears both flags; an error event in the same cycle wins, and the flag stays set.

Reset
REQ-027 rst_n low at any time, including mid-fetch, forces IDLE with counters, base, the pending lb_we pipeline bit, overrun and range_err at 0.
REQ-028 During reset, all outputs are 0: ram_en, ram_we, lb_we, line_busy, line_done and wr_ready; no partial line is completed after release.

Configuration
REQ-029 Macro VRAM_ARB_PERF_EN defined: adds outputs host_stall_cnt (16 bits, counts cycles with wr_valid && !wr_ready) and overrun_cnt (8 bits, counts overrun events); both saturate, clear on reset and on err_clr.
REQ-030 VRAM_ARB_PERF_EN undefined: those ports and counters are absent, and all other behaviour is identical.

Structure
REQ-031 Package vram_pkg holds the FSM state enum, the default parameter constants and the clog2(LINE_LEN)-based index width constant.
REQ-032 Single module with no sub-modules; the perf counters are an inline conditional block.

Verification
REQ-033 line_req with line_idx=2 and no host traffic -> reads at addresses 320..479 in 160 consecutive cycles, lb_addr 0..159, line_done in cycle T+161.
REQ-034 line_req with wr_valid held high and wr_addr=0x100 -> yields after reads 16, 32, ..., 144 (9 yields), line_done in cycle T+170, each yield writes 0x100.
REQ-035 line_req and wr_valid in the same IDLE cycle -> wr_ready=0, fetch starts, the write is accepted at the first yield point.
REQ-036 Second line_req 50 cycles into a fetch -> overrun=1, first line completes normally; err_clr -> overrun=0.
REQ-037 line_idx=120 -> range_err=1, no ram_en; rst_n low at offset 80 of a fetch -> all outputs 0, no line_done after release.
REQ-038 With VRAM_ARB_PERF_EN: host blocked for 70000 cycles -> host_stall_cnt=65535.
